// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a post-reset clear sequencer.
// Optional feature macro: RF_BYPASS_EN (write-first forwarding on read/write collision).
module regfile_param #(
    parameter int               DATA_W   = 32,
    parameter int               ADDR_W   = 5,
    parameter int               DEPTH    = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rd_valid,
    input  logic              we,
    input  logic [ADDR_W-1:0] wd_addr,
    input  logic [DATA_W-1:0] wd_data,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [DATA_W-1:0]   rs_data_q, rt_data_q;
    logic                rd_valid_q, busy_q;

    logic                mem_we_s;
    logic [ADDR_W-1:0]   mem_waddr_s;
    logic [DATA_W-1:0]   mem_wdata_s;
    logic                wr_ok_s;
    logic                rd_fire_s;
    logic [DATA_W-1:0]   rs_next_s, rt_next_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C);
    endfunction

    // Entry 0 and unmapped addresses read as zero; optional same-edge write forwarding.
    function automatic logic [DATA_W-1:0] port_value(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = {DATA_W{1'b0}};
        if (in_range(a) && (a != {ADDR_W{1'b0}})) begin
`ifdef RF_BYPASS_EN
            if (we && (state_q == ST_READY) && (wd_addr == a)) begin
                v = wd_data;
            end else begin
                v = mem_q[a];
            end
`else
            v = mem_q[a];
`endif
        end else begin
            v = {DATA_W{1'b0}};
        end
        return v;
    endfunction

    // State and clear-counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= {ADDR_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: walk every entry once, then park in READY until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q == LAST_C) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_READY: state_d = ST_READY;
            default: begin
                state_d = ST_INIT;
                cnt_d   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Array write source: sequencer during INIT, user port only when READY.
    always_comb begin
        wr_ok_s     = in_range(wd_addr) && (wd_addr != {ADDR_W{1'b0}});
        mem_we_s    = 1'b0;
        mem_waddr_s = cnt_q;
        mem_wdata_s = INIT_VAL;
        if (state_q == ST_INIT) begin
            mem_we_s = 1'b1;
        end else if (we && wr_ok_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = wd_addr;
            mem_wdata_s = wd_data;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Storage array; contents are undefined until the clear sequence reaches them.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end else begin
            mem_q[mem_waddr_s] <= mem_q[mem_waddr_s];
        end
    end

    // Read-port next values.
    always_comb begin
        rd_fire_s = rd_en && (state_q == ST_READY);
        rs_next_s = port_value(rs_addr);
        rt_next_s = port_value(rt_addr);
    end

    // Registered outputs; data holds when no read fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_data_q  <= {DATA_W{1'b0}};
            rt_data_q  <= {DATA_W{1'b0}};
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            if (rd_fire_s) begin
                rs_data_q <= rs_next_s;
                rt_data_q <= rt_next_s;
            end else begin
                rs_data_q <= rs_data_q;
                rt_data_q <= rt_data_q;
            end
            rd_valid_q <= rd_fire_s;
            busy_q     <= (state_d == ST_INIT);
        end
    end

    assign rs_data  = rs_data_q;
    assign rt_data  = rt_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param (DEPTH=8, ADDR_W=5, nonzero INIT_VAL).
module tb_regfile_param;

    localparam int          DW    = 32;
    localparam int          AW    = 5;
    localparam int          DEP   = 8;
    localparam logic [31:0] INITV = 32'h0000_00C3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rs_addr = '0;
    logic [AW-1:0] rt_addr = '0;
    logic [DW-1:0] rs_data, rt_data;
    logic          rd_valid;
    logic          we = 1'b0;
    logic [AW-1:0] wd_addr = '0;
    logic [DW-1:0] wd_data = '0;
    logic          busy;

    int            errs   = 0;
    int            checks = 0;
    logic [31:0]   model [DEP];

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .INIT_VAL(INITV)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data), .rd_valid(rd_valid),
        .we(we), .wd_addr(wd_addr), .wd_data(wd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic rd(input int a, input int b);
        rd_en   = 1'b1;
        rs_addr = AW'(a);
        rt_addr = AW'(b);
        tick;
        rd_en = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        we      = 1'b1;
        wd_addr = AW'(a);
        wd_data = d;
        tick;
        we = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < DEP; i++) begin
            rd(i, DEP - 1 - i);
            chk({tag, "_rs"}, rs_data, (i == 0) ? 32'h0 : model[i]);
            chk({tag, "_rt"}, rt_data, (DEP - 1 - i == 0) ? 32'h0 : model[DEP - 1 - i]);
        end
    endtask

    task automatic count_busy(output int n, output int bad_valid);
        n = 0;
        bad_valid = 0;
        while (busy && n < 200) begin
            tick;
            n++;
            if (rd_valid) bad_valid++;
        end
    endtask

    initial begin
        int n;
        int bad;
        for (int i = 0; i < DEP; i++) model[i] = INITV;

        tick;
        tick;
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_valid", 32'(rd_valid), 32'h0);
        chk("rst_rs", rs_data, 32'h0);
        chk("rst_rt", rt_data, 32'h0);

        rst = 1'b0;
        count_busy(n, bad);
        chk("init_busy_cycles", 32'(n), 32'(DEP));
        check_all("init");
        chk("init_valid", 32'(rd_valid), 32'h1);

        wr(3, 32'h5);
        model[3] = 32'h5;
        rd(3, 0);
        chk("wr3_rs", rs_data, 32'h5);
        chk("wr3_rt", rt_data, 32'h0);
        chk("wr3_valid", 32'(rd_valid), 32'h1);
        tick;
        chk("hold_valid", 32'(rd_valid), 32'h0);
        chk("hold_rs", rs_data, 32'h5);

        wr(0, 32'hFFFF);
        rd(0, 0);
        chk("zero_rs", rs_data, 32'h0);
        chk("zero_rt", rt_data, 32'h0);
        rd(9, 3);
        chk("oor_rs", rs_data, 32'h0);
        chk("oor_rt", rt_data, 32'h5);
        wr(9, 32'hDEAD);
        check_all("oor_wr");

        wr(4, 32'h7);
        we = 1'b1; wd_addr = AW'(4); wd_data = 32'h9;
        rd_en = 1'b1; rs_addr = AW'(4); rt_addr = AW'(4);
        tick;
        we = 1'b0; rd_en = 1'b0;
        model[4] = 32'h9;
`ifdef RF_BYPASS_EN
        chk("coll_rs", rs_data, 32'h9);
        chk("coll_rt", rt_data, 32'h9);
`else
        chk("coll_rs", rs_data, 32'h7);
        chk("coll_rt", rt_data, 32'h7);
`endif
        rd(4, 4);
        chk("coll_after_rs", rs_data, 32'h9);
        chk("coll_after_rt", rt_data, 32'h9);

        wr(1, 32'h5);
        rd(1, 1);
        chk("pre_rst_rs", rs_data, 32'h5);
        rst = 1'b1;
        #1;
        chk("mid_rst_rs", rs_data, 32'h0);
        chk("mid_rst_rt", rt_data, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h1);
        tick;
        rst = 1'b0;
        we = 1'b1; wd_addr = AW'(2); wd_data = 32'hA;
        rd_en = 1'b1; rs_addr = AW'(2); rt_addr = AW'(1);
        count_busy(n, bad);
        we = 1'b0; rd_en = 1'b0;
        chk("mid_busy_cycles", 32'(n), 32'(DEP));
        chk("gate_valid", 32'(bad), 32'h0);
        for (int i = 0; i < DEP; i++) model[i] = INITV;
        check_all("reinit");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
